dds_wave_gen: RTL and testbench



---
 rtl/dds_wave_gen.sv | 119 +++++++++++
 tb/tb_dds_wave_gen.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_wave_gen.sv
`default_nettype none
// ============================================================================
//  Module      : dds_wave_gen
//  Description : Parametrised DDS waveform generator. A phase accumulator
//                advances by FTW on each enabled clock. The generator produces
//                registered saw, reverse saw, triangle, square and pulse
//                samples. Waveform and duty changes are applied at period
//                boundaries, so switching between them is glitch-free.
//  Revision    : 1.0  initial release
// ============================================================================
module dds_wave_gen #(
    parameter int PHASE_W = 32,
    parameter int OUT_W   = 8,
    parameter int DUTY_W  = 8
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               EN,
    input  logic               SYNC,
    input  logic [PHASE_W-1:0] FTW,
    input  logic [2:0]         FORM,
    input  logic [DUTY_W-1:0]  DUTY,
    output logic [OUT_W-1:0]   WAVE,
    output logic               WRAP,
    output logic [2:0]         FORM_ACT
);

    localparam logic [2:0] FORM_SAW   = 3'b000;
    localparam logic [2:0] FORM_RSAW  = 3'b001;
    localparam logic [2:0] FORM_TRI   = 3'b010;
    localparam logic [2:0] FORM_SQ50  = 3'b011;
    localparam logic [2:0] FORM_PULSE = 3'b100;
    localparam logic [2:0] FORM_SQ25  = 3'b101;

    localparam logic [OUT_W-1:0]  C_MAX       = {OUT_W{1'b1}};
    localparam logic [OUT_W-1:0]  C_MID       = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [DUTY_W-1:0] C_DUTY_RST  = {1'b1, {(DUTY_W-1){1'b0}}};

    logic [PHASE_W-1:0] acc_q,      acc_d;
    logic               carry_q,    carry_d;
    logic [2:0]         form_act_q, form_act_d;
    logic [DUTY_W-1:0]  duty_act_q, duty_act_d;
    logic [OUT_W-1:0]   wave_q,     wave_d;
    logic               wrap_q,     wrap_d;

    logic [PHASE_W:0]   w_sum;
    logic [OUT_W-1:0]   w_p;
    logic [DUTY_W-1:0]  w_d;
    logic [OUT_W-1:0]   w_tri;

    // Phase accumulator, carry and active form/duty selection (SYNC beats EN)
    always_comb begin
        w_sum      = {1'b0, acc_q} + {1'b0, FTW};
        acc_d      = acc_q;
        carry_d    = carry_q;
        form_act_d = form_act_q;
        duty_act_d = duty_act_q;
        if (SYNC) begin
            acc_d      = '0;
            carry_d    = 1'b0;
            form_act_d = FORM;
            duty_act_d = DUTY;
        end else if (EN) begin
            acc_d   = w_sum[PHASE_W-1:0];
            carry_d = w_sum[PHASE_W];
            // A new period begins, so the pending form and duty take over here
            if (w_sum[PHASE_W]) begin
                form_act_d = FORM;
                duty_act_d = DUTY;
            end
        end else begin
            carry_d    = 1'b0;
            form_act_d = FORM;
            duty_act_d = DUTY;
        end
    end

    // Sample stage: map the current phase to a waveform sample
    always_comb begin
        w_p    = acc_q[PHASE_W-1 -: OUT_W];
        w_d    = acc_q[PHASE_W-1 -: DUTY_W];
        w_tri  = {w_p[OUT_W-2:0], 1'b0};
        wrap_d = carry_q;
        case (form_act_q)
            FORM_SAW:   wave_d = w_p;
            FORM_RSAW:  wave_d = C_MAX - w_p;
            FORM_TRI:   wave_d = w_p[OUT_W-1] ? ~w_tri : w_tri;
            FORM_SQ50:  wave_d = w_p[OUT_W-1] ? '0 : C_MAX;
            FORM_PULSE: wave_d = (w_d < duty_act_q) ? C_MAX : '0;
            FORM_SQ25:  wave_d = (w_p[OUT_W-1:OUT_W-2] == 2'b00) ? C_MAX : '0;
            default:    wave_d = C_MID;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RESET) begin
            acc_q      <= '0;
            carry_q    <= 1'b0;
            form_act_q <= 3'b000;
            duty_act_q <= C_DUTY_RST;
            wave_q     <= '0;
            wrap_q     <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            carry_q    <= carry_d;
            form_act_q <= form_act_d;
            duty_act_q <= duty_act_d;
            wave_q     <= wave_d;
            wrap_q     <= wrap_d;
        end
    end

    assign WAVE     = wave_q;
    assign WRAP     = wrap_q;
    assign FORM_ACT = form_act_q;

endmodule
`default_nettype wire

// File: tb/tb_dds_wave_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dds_wave_gen
//  Description : Self-checking bench for dds_wave_gen: reference model feeds
//                an expectation queue, plus directed checks of key samples.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dds_wave_gen;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        EN;
    logic        SYNC;
    logic [31:0] FTW;
    logic [2:0]  FORM;
    logic [7:0]  DUTY;
    logic [7:0]  WAVE;
    logic        WRAP;
    logic [2:0]  FORM_ACT;

    dds_wave_gen #(.PHASE_W(32), .OUT_W(8), .DUTY_W(8)) dut (
        .CLK(CLK), .RESET(RESET), .EN(EN), .SYNC(SYNC), .FTW(FTW),
        .FORM(FORM), .DUTY(DUTY), .WAVE(WAVE), .WRAP(WRAP), .FORM_ACT(FORM_ACT)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [7:0] wave;
        logic       wrap;
        logic [2:0] form;
    } exp_t;

    exp_t sb_q[$];

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    logic [31:0] m_acc;
    logic        m_carry;
    logic [2:0]  m_form;
    logic [7:0]  m_duty;

    function automatic logic [7:0] ref_wave(input logic [31:0] acc,
                                            input logic [2:0] form,
                                            input logic [7:0] duty);
        int p;
        p = int'(acc >> 24);
        case (form)
            3'd0: return 8'(p);
            3'd1: return 8'(255 - p);
            3'd2: return (p < 128) ? 8'(2 * p) : 8'(255 - 2 * (p - 128));
            3'd3: return (p < 128) ? 8'd255 : 8'd0;
            3'd4: return (p < int'(duty)) ? 8'd255 : 8'd0;
            3'd5: return (p < 64) ? 8'd255 : 8'd0;
            default: return 8'd128;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: push model prediction, advance, pop and compare
    task automatic tick();
        exp_t   e;
        exp_t   got;
        logic [32:0] sum;
        if (RESET) begin
            e.wave  = 8'd0;
            e.wrap  = 1'b0;
            m_acc   = '0;
            m_carry = 1'b0;
            m_form  = 3'd0;
            m_duty  = 8'h80;
        end else begin
            e.wave = ref_wave(m_acc, m_form, m_duty);
            e.wrap = m_carry;
            if (SYNC) begin
                m_acc   = '0;
                m_carry = 1'b0;
                m_form  = FORM;
                m_duty  = DUTY;
            end else if (EN) begin
                sum     = {1'b0, m_acc} + {1'b0, FTW};
                m_acc   = sum[31:0];
                m_carry = sum[32];
                if (sum[32]) begin
                    m_form = FORM;
                    m_duty = DUTY;
                end
            end else begin
                m_carry = 1'b0;
                m_form  = FORM;
                m_duty  = DUTY;
            end
        end
        e.form = m_form;
        sb_q.push_back(e);
        @(posedge CLK);
        #1;
        got = sb_q.pop_front();
        check("sb_wave", 32'(WAVE), 32'(got.wave));
        check("sb_wrap", 32'(WRAP), 32'(got.wrap));
        check("sb_form_act", 32'(FORM_ACT), 32'(got.form));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Advance until WRAP is seen, bounded; expiry counts as a failure
    task automatic wait_wrap(input int bound);
        int k;
        k = 0;
        tick();
        while (WRAP !== 1'b1 && k < bound) begin
            tick();
            k++;
        end
        check("wrap_timeout", 32'(WRAP), 32'd1);
    endtask

    int wrap_cnt;
    int nonzero;

    initial begin
        RESET = 1'b1; EN = 1'b1; SYNC = 1'b0;
        FTW = 32'h0100_0000; FORM = 3'd0; DUTY = 8'h80;
        m_acc = '0; m_carry = 1'b0; m_form = 3'd0; m_duty = 8'h80;

        // 1. reset then saw
        ticks(2);
        check("rst_wave", 32'(WAVE), 32'd0);
        check("rst_wrap", 32'(WRAP), 32'd0);
        check("rst_form", 32'(FORM_ACT), 32'd0);
        RESET = 1'b0;
        ticks(2);
        check("saw_first", 32'(WAVE), 32'd1);
        wrap_cnt = 0;
        for (int i = 0; i < 512; i++) begin
            tick();
            if (WRAP === 1'b1) begin
                wrap_cnt++;
                check("saw_wrap_wave", 32'(WAVE), 32'd0);
            end
        end
        check("saw_wrap_count", 32'(wrap_cnt), 32'd2);

        // 2. triangle
        FORM = 3'd2;
        wait_wrap(300);
        check("tri_p0", 32'(WAVE), 32'd0);
        check("tri_form", 32'(FORM_ACT), 32'd2);
        ticks(127);
        check("tri_p127", 32'(WAVE), 32'd254);
        tick();
        check("tri_p128", 32'(WAVE), 32'd255);
        ticks(127);
        check("tri_p255", 32'(WAVE), 32'd1);
        tick();
        check("tri_wrap_wave", 32'(WAVE), 32'd0);
        check("tri_wrap", 32'(WRAP), 32'd1);

        // 3. saw -> square switch mid-period
        FORM = 3'd0;
        wait_wrap(300);
        ticks(64);
        check("sw_0x40", 32'(WAVE), 32'h40);
        FORM = 3'd3;
        ticks(191);
        check("sw_saw_end", 32'(WAVE), 32'd255);
        check("sw_no_wrap", 32'(WRAP), 32'd0);
        tick();
        check("sw_wrap", 32'(WRAP), 32'd1);
        check("sw_sq_p0", 32'(WAVE), 32'd255);
        check("sw_form", 32'(FORM_ACT), 32'd3);
        ticks(128);
        check("sw_sq_p80", 32'(WAVE), 32'd0);

        // 4. pulse with duty 0x40, then duty 0
        FORM = 3'd4; DUTY = 8'h40;
        wait_wrap(300);
        check("pulse_p0", 32'(WAVE), 32'd255);
        ticks(63);
        check("pulse_p63", 32'(WAVE), 32'd255);
        tick();
        check("pulse_p64", 32'(WAVE), 32'd0);
        DUTY = 8'h00;
        wait_wrap(300);
        nonzero = (WAVE !== 8'd0) ? 1 : 0;
        for (int i = 0; i < 255; i++) begin
            tick();
            if (WAVE !== 8'd0) nonzero++;
        end
        check("pulse_duty0", 32'(nonzero), 32'd0);

        // 5. SYNC with reverse saw pending
        FORM = 3'd0;
        wait_wrap(300);
        ticks(8'h8f);
        FORM = 3'd1; SYNC = 1'b1;
        tick();
        SYNC = 1'b0;
        tick();
        check("sync_wave", 32'(WAVE), 32'd255);
        check("sync_wrap", 32'(WRAP), 32'd0);
        check("sync_form", 32'(FORM_ACT), 32'd1);

        // 6a. EN=0 hold and immediate form update
        EN = 1'b0;
        tick();
        check("hold_a", 32'(WAVE), 32'd254);
        tick();
        check("hold_b", 32'(WAVE), 32'd254);
        FORM = 3'd3;
        tick();
        check("idle_form", 32'(FORM_ACT), 32'd3);
        check("idle_wave", 32'(WAVE), 32'd254);
        tick();
        check("idle_sq", 32'(WAVE), 32'd255);

        // 6b. FTW all-ones from reset
        RESET = 1'b1; EN = 1'b1; FORM = 3'd0; FTW = 32'hFFFF_FFFF;
        ticks(2);
        RESET = 1'b0;
        tick();
        check("ff_e1", 32'(WRAP), 32'd0);
        tick();
        check("ff_e2", 32'(WRAP), 32'd0);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("ff_wrap_on", 32'(WRAP), 32'd1);
        end

        // 6c. FTW=0 with EN: no loads until idle
        FTW = 32'd0; FORM = 3'd5;
        ticks(4);
        check("ftw0_form", 32'(FORM_ACT), 32'd0);
        EN = 1'b0;
        tick();
        check("ftw0_idle", 32'(FORM_ACT), 32'd5);
        FORM = 3'd6;
        ticks(2);
        check("reserved_mid", 32'(WAVE), 32'd128);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
